conv_window_sched: RTL

- Sequencer for the NBITS-wide KxK convolution datapath: K=3, 5 or 6, matching the 9-, 25- and 36-coefficient windows and their CSA adder trees.
- Accepts a raster pixel stream and drives the line-buffer writes, the window-shift strobes and the MAC launch strobes.
- Tracks the datapath pipeline latency and signals frame completion.
- Sits between the pixel source and the line-buffer/window/CSA datapath; it holds no pixel data.

---
 rtl/conv_window_sched.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/conv_window_sched.sv
// Sequencer for the KxK convolution datapath: line-buffer writes, window shifts,
// MAC launches and result-latency tracking. Optional CONV_STRIDE2_EN adds a stride-2 launch mode.
module conv_window_sched #(
  parameter int IMG_W    = 8,
  parameter int IMG_H    = 6,
  parameter int K        = 3,
  parameter int PIPE_LAT = 3,
  parameter int CW       = $clog2(IMG_W),
  parameter int RW       = $clog2(IMG_H)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
`ifdef CONV_STRIDE2_EN
  input  logic                 stride2,
`endif
  output logic                 busy,
  output logic                 done,
  input  logic                 pix_valid,
  output logic                 pix_ready,
  output logic                 lb_wr_en,
  output logic [CW-1:0]        lb_col,
  output logic [$clog2(K)-1:0] lb_row_sel,
  output logic                 win_shift,
  output logic                 mac_en,
  output logic                 pipe_en,
  input  logic                 out_ready,
  output logic                 res_valid,
  output logic [15:0]          res_count
);
  localparam int SW = $clog2(K);
  localparam logic [CW-1:0] COL_FIRST = CW'(K - 1);
  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_FIRST = RW'(K - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
  localparam logic [SW-1:0] SEL_LAST  = SW'(K - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         col_q, col_d;
  logic [RW-1:0]         row_q, row_d;
  logic [SW-1:0]         sel_q, sel_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [PIPE_LAT-1:0]   lat_q, lat_d;
  logic                  acc;
  logic                  win_ok;
`ifdef CONV_STRIDE2_EN
  logic                  stride_q, stride_d;
`endif

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    sel_d     = sel_q;
    cnt_d     = cnt_q;
    lat_d     = lat_q;
    busy      = 1'b0;
    done      = 1'b0;
    pix_ready = 1'b0;
    acc       = 1'b0;
    mac_en    = 1'b0;
    win_ok    = (row_q >= ROW_FIRST) && (col_q >= COL_FIRST);
`ifdef CONV_STRIDE2_EN
    stride_d  = stride_q;
    if (stride_q)
      win_ok = win_ok && (row_q[0] == ROW_FIRST[0]) && (col_q[0] == COL_FIRST[0]);
`endif
    if (lat_q[PIPE_LAT-1] && out_ready)
      cnt_d = cnt_q + 16'd1;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          col_d   = '0;
          row_d   = '0;
          sel_d   = '0;
          cnt_d   = '0;
`ifdef CONV_STRIDE2_EN
          stride_d = stride2;
`endif
        end
      end
      S_RUN: begin
        busy      = 1'b1;
        pix_ready = out_ready & ~reset;
        acc       = pix_valid & pix_ready;
        mac_en    = acc & win_ok;
        if (acc) begin
          if (col_q == COL_LAST) begin
            col_d = '0;
            row_d = row_q + RW'(1);
            sel_d = (sel_q == SEL_LAST) ? '0 : sel_q + SW'(1);
            if (row_q == ROW_LAST)
              state_d = S_FLUSH;
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
      S_FLUSH: busy = 1'b1;
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Truncating the concat drops the old tail bit; also valid for PIPE_LAT == 1.
    if (out_ready)
      lat_d = PIPE_LAT'({lat_q, mac_en});
    if (state_q == S_FLUSH && lat_d == '0)
      state_d = S_DONE;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      sel_q   <= '0;
      cnt_q   <= '0;
      lat_q   <= '0;
`ifdef CONV_STRIDE2_EN
      stride_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      lat_q   <= lat_d;
`ifdef CONV_STRIDE2_EN
      stride_q <= stride_d;
`endif
    end
  end

  assign lb_wr_en   = acc;
  assign win_shift  = acc;
  assign lb_col     = col_q;
  assign lb_row_sel = sel_q;
  assign pipe_en    = out_ready;
  assign res_valid  = lat_q[PIPE_LAT-1];
  assign res_count  = cnt_q;
endmodule
